// File: rtl/cic_out_quant.sv
// Output quantizer for the CIC interpolator: rounded arithmetic right shift, saturation to the
// DAC word width, per-sample clip flag, and host-visible clip counter and peak-magnitude register.
module cic_out_quant #(
    parameter int unsigned Win  = 38,
    parameter int unsigned Wout = 16,
    parameter int unsigned Wsh  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [Win-1:0]  i_data,
    input  logic                   val_in,
    input  logic        [Wsh-1:0]  shift,
    input  logic                   clr_stat,
    output logic signed [Wout-1:0] o_data,
    output logic                   val_out,
    output logic                   sat_flag,
    output logic        [15:0]     sat_count,
    output logic        [Wout-1:0] peak
);

    localparam logic signed [Win:0] MaxV = {{(Win - Wout + 2){1'b0}}, {(Wout - 1){1'b1}}};
    localparam logic signed [Win:0] MinV = {{(Win - Wout + 2){1'b1}}, {(Wout - 1){1'b0}}};

    int unsigned          s_eff;
    logic signed [Win:0]  ext, rnd, sum, s1_d, s1_q;
    logic                 v1_q;
    logic signed [Wout-1:0] s2_d, s2_q;
    logic                 f2_d, f2_q, v2_q;
    logic [Wout-1:0]      s2_u, mag;
    logic signed [Wout-1:0] o_data_q;
    logic                 val_out_q, sat_flag_q;
    logic [15:0]          sat_count_d, sat_count_q;
    logic [Wout-1:0]      peak_d, peak_q;

    // Stage 1: the extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        s_eff = (32'(shift) > Win - 1) ? Win - 1 : 32'(shift);
        ext   = {i_data[Win-1], i_data};
        rnd   = '0;
        if (s_eff != 0) begin
            rnd = (Win + 1)'(1) << (s_eff - 1);
        end
        sum  = ext + rnd;
        s1_d = sum >>> s_eff;
    end

    always_comb begin
        s2_d = s1_q[Wout-1:0];
        f2_d = 1'b0;
        if (s1_q > MaxV) begin
            s2_d = MaxV[Wout-1:0];
            f2_d = 1'b1;
        end else if (s1_q < MinV) begin
            s2_d = MinV[Wout-1:0];
            f2_d = 1'b1;
        end
    end

    // Unsigned magnitude so that the most negative code maps to 2^(Wout-1).
    always_comb begin
        s2_u = s2_q;
        mag  = s2_u[Wout-1] ? (~s2_u) + 1'b1 : s2_u;
    end

    always_comb begin
        sat_count_d = sat_count_q;
        peak_d      = peak_q;
        if (clr_stat) begin
            sat_count_d = '0;
            peak_d      = '0;
        end else if (v2_q) begin
            if (f2_q && sat_count_q != 16'hFFFF) begin
                sat_count_d = sat_count_q + 16'd1;
            end
            if (mag > peak_q) begin
                peak_d = mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            s2_q        <= '0;
            f2_q        <= 1'b0;
            v2_q        <= 1'b0;
            o_data_q    <= '0;
            val_out_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
            peak_q      <= '0;
        end else begin
            v1_q        <= val_in;
            v2_q        <= v1_q;
            val_out_q   <= v2_q;
            sat_count_q <= sat_count_d;
            peak_q      <= peak_d;
            if (val_in) begin
                s1_q <= s1_d;
            end
            if (v1_q) begin
                s2_q <= s2_d;
                f2_q <= f2_d;
            end
            if (v2_q) begin
                o_data_q   <= s2_q;
                sat_flag_q <= f2_q;
            end
        end
    end

    assign o_data    = o_data_q;
    assign val_out   = val_out_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;
    assign peak      = peak_q;

endmodule
